// File: rtl/hazard_ctrl.sv
// Pipeline hazard and redirect controller: per-stage stall/flush,
// stale fetch-response discard after redirect, and stall/flush counters.
module hazard_ctrl #(
    parameter bit W_BYPASS = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_ok,
    input  logic        d_valid,
    input  logic [4:0]  d_ra1,
    input  logic [4:0]  d_ra2,
    input  logic        d_use1,
    input  logic        d_use2,
    input  logic        d_is_jump,
    input  logic        e_valid,
    input  logic        m_valid,
    input  logic        w_valid,
    input  logic [4:0]  e_dst,
    input  logic [4:0]  m_dst,
    input  logic [4:0]  w_dst,
    input  logic        e_wen,
    input  logic        m_wen,
    input  logic        w_wen,
    input  logic        m_busy,
    output logic        stall_f,
    output logic        stall_d,
    output logic        stall_e,
    output logic        stall_m,
    output logic        flush_d,
    output logic        flush_e,
    output logic        flush_w,
    output logic        drop_resp,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic {
        RUN  = 1'b0,
        DROP = 1'b1
    } state_t;

    state_t state;

    function automatic logic hit(
        input logic       v,
        input logic       wen,
        input logic [4:0] dst,
        input logic [4:0] ra
    );
        return v & wen & (dst != 5'd0) & (dst == ra);
    endfunction

    logic raw1;
    logic raw2;
    logic raw;
    logic in_drop;
    logic sel_mem;
    logic sel_raw;
    logic sel_drop;
    logic sel_jump;
    logic sel_fetch;

    // Decode reads the register file directly, so any pending writer stalls.
    assign raw1 = d_valid & d_use1 &
                  (hit(e_valid, e_wen, e_dst, d_ra1) |
                   hit(m_valid, m_wen, m_dst, d_ra1) |
                   (!W_BYPASS & hit(w_valid, w_wen, w_dst, d_ra1)));
    assign raw2 = d_valid & d_use2 &
                  (hit(e_valid, e_wen, e_dst, d_ra2) |
                   hit(m_valid, m_wen, m_dst, d_ra2) |
                   (!W_BYPASS & hit(w_valid, w_wen, w_dst, d_ra2)));
    assign raw  = raw1 | raw2;

    assign in_drop   = (state == DROP);
    assign sel_mem   = m_busy;
    assign sel_raw   = !m_busy & raw;
    assign sel_drop  = !m_busy & !raw & in_drop;
    assign sel_jump  = !m_busy & !raw & !in_drop & d_is_jump;
    assign sel_fetch = !m_busy & !raw & !in_drop & !d_is_jump & !f_ok;

    always_comb begin
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        stall_e   = 1'b0;
        stall_m   = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        flush_w   = 1'b0;
        drop_resp = 1'b0;
        if (reset) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_w = 1'b1;
        end else begin
            drop_resp = in_drop & f_ok;
            unique case (1'b1)
                sel_mem: begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    stall_m = 1'b1;
                    flush_w = 1'b1;
                end
                sel_raw: begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end
                sel_drop: begin
                    stall_f = !f_ok;
                    flush_d = 1'b1;
                end
                sel_jump: begin
                    flush_d = 1'b1;
                end
                sel_fetch: begin
                    stall_f = 1'b1;
                    flush_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            unique case (state)
                RUN:  if (sel_jump && !f_ok) state <= DROP;
                DROP: if (f_ok) state <= RUN;
                default: state <= RUN;
            endcase
            if (stall_d && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
            if (sel_jump && flush_cnt != 32'hFFFF_FFFF)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with immediate-assertion checks.
module tb_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic        f_ok;
    logic        d_valid;
    logic [4:0]  d_ra1;
    logic [4:0]  d_ra2;
    logic        d_use1;
    logic        d_use2;
    logic        d_is_jump;
    logic        e_valid;
    logic        m_valid;
    logic        w_valid;
    logic [4:0]  e_dst;
    logic [4:0]  m_dst;
    logic [4:0]  w_dst;
    logic        e_wen;
    logic        m_wen;
    logic        w_wen;
    logic        m_busy;
    logic        stall_f;
    logic        stall_d;
    logic        stall_e;
    logic        stall_m;
    logic        flush_d;
    logic        flush_e;
    logic        flush_w;
    logic        drop_resp;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    int passed = 0;
    int total  = 0;

    hazard_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .f_ok      (f_ok),
        .d_valid   (d_valid),
        .d_ra1     (d_ra1),
        .d_ra2     (d_ra2),
        .d_use1    (d_use1),
        .d_use2    (d_use2),
        .d_is_jump (d_is_jump),
        .e_valid   (e_valid),
        .m_valid   (m_valid),
        .w_valid   (w_valid),
        .e_dst     (e_dst),
        .m_dst     (m_dst),
        .w_dst     (w_dst),
        .e_wen     (e_wen),
        .m_wen     (m_wen),
        .w_wen     (w_wen),
        .m_busy    (m_busy),
        .stall_f   (stall_f),
        .stall_d   (stall_d),
        .stall_e   (stall_e),
        .stall_m   (stall_m),
        .flush_d   (flush_d),
        .flush_e   (flush_e),
        .flush_w   (flush_w),
        .drop_resp (drop_resp),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bit order: stall_f stall_d stall_e stall_m flush_d flush_e flush_w drop_resp
    logic [7:0] ctl;
    assign ctl = {stall_f, stall_d, stall_e, stall_m,
                  flush_d, flush_e, flush_w, drop_resp};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        f_ok = 1'b1; d_valid = 1'b0; d_ra1 = 5'd0; d_ra2 = 5'd0;
        d_use1 = 1'b0; d_use2 = 1'b0; d_is_jump = 1'b0;
        e_valid = 1'b0; m_valid = 1'b0; w_valid = 1'b0;
        e_dst = 5'd0; m_dst = 5'd0; w_dst = 5'd0;
        e_wen = 1'b0; m_wen = 1'b0; w_wen = 1'b0; m_busy = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        tick();
        tick();
        chk("reset_ctl", {24'd0, ctl}, 32'h0E);
        chk("reset_scnt", stall_cnt, 32'd0);
        chk("reset_fcnt", flush_cnt, 32'd0);
        reset = 1'b0;
        #1;
        chk("idle", {24'd0, ctl}, 32'h00);

        // load-use: writer in E, then M, then W
        d_valid = 1'b1; d_ra1 = 5'd5; d_use1 = 1'b1;
        e_valid = 1'b1; e_dst = 5'd5; e_wen = 1'b1;
        #1 chk("raw_e", {24'd0, ctl}, 32'hC4);
        tick();
        e_valid = 1'b0; e_wen = 1'b0;
        m_valid = 1'b1; m_dst = 5'd5; m_wen = 1'b1;
        #1 chk("raw_m", {24'd0, ctl}, 32'hC4);
        tick();
        m_valid = 1'b0; m_wen = 1'b0;
        w_valid = 1'b1; w_dst = 5'd5; w_wen = 1'b1;
        #1 chk("raw_w", {24'd0, ctl}, 32'hC4);
        tick();
        w_valid = 1'b0; w_wen = 1'b0;
        #1 chk("raw_clear", {24'd0, ctl}, 32'h00);
        chk("raw_scnt", stall_cnt, 32'd3);

        // x0 and unused source
        idle();
        d_valid = 1'b1; d_ra1 = 5'd0; d_use1 = 1'b1;
        e_valid = 1'b1; e_dst = 5'd0; e_wen = 1'b1;
        #1 chk("x0", {24'd0, ctl}, 32'h00);
        d_ra1 = 5'd3; d_ra2 = 5'd7; d_use2 = 1'b0; e_dst = 5'd7;
        #1 chk("unused_src", {24'd0, ctl}, 32'h00);
        tick();
        chk("x0_scnt", stall_cnt, 32'd3);

        // jump with response ready
        idle();
        d_valid = 1'b1; d_is_jump = 1'b1;
        #1 chk("jump_ok", {24'd0, ctl}, 32'h08);
        tick();
        chk("jump_ok_fcnt", flush_cnt, 32'd1);
        idle();
        #1 chk("jump_ok_run", {24'd0, ctl}, 32'h00);
        tick();

        // jump with fetch pending, stale response three cycles later
        d_valid = 1'b1; d_is_jump = 1'b1; f_ok = 1'b0;
        #1 chk("jump_pend", {24'd0, ctl}, 32'h08);
        tick();
        chk("jump_pend_fcnt", flush_cnt, 32'd2);
        #1 chk("drop1", {24'd0, ctl}, 32'h88);
        tick();
        chk("drop1_fcnt", flush_cnt, 32'd2);
        d_valid = 1'b0; d_is_jump = 1'b0;
        #1 chk("drop2", {24'd0, ctl}, 32'h88);
        tick();
        f_ok = 1'b1;
        #1 chk("drop3_resp", {24'd0, ctl}, 32'h09);
        tick();
        #1 chk("drop_back_run", {24'd0, ctl}, 32'h00);
        chk("drop_scnt", stall_cnt, 32'd3);
        tick();

        // mem beats raw beats jump
        idle();
        m_busy = 1'b1; d_valid = 1'b1; d_is_jump = 1'b1;
        d_ra1 = 5'd9; d_use1 = 1'b1;
        e_valid = 1'b1; e_dst = 5'd9; e_wen = 1'b1;
        #1 chk("prio_mem", {24'd0, ctl}, 32'hF2);
        tick();
        m_busy = 1'b0;
        #1 chk("prio_raw", {24'd0, ctl}, 32'hC4);
        tick();
        e_valid = 1'b0;
        #1 chk("prio_jump", {24'd0, ctl}, 32'h08);
        tick();
        chk("prio_fcnt", flush_cnt, 32'd3);
        chk("prio_scnt", stall_cnt, 32'd5);

        // fetch stall
        idle();
        f_ok = 1'b0;
        #1 chk("fetch", {24'd0, ctl}, 32'h88);
        tick();
        chk("fetch_scnt", stall_cnt, 32'd5);

        // mem coinciding with DROP
        d_valid = 1'b1; d_is_jump = 1'b1; f_ok = 1'b0;
        #1 chk("jump2", {24'd0, ctl}, 32'h08);
        tick();
        idle();
        f_ok = 1'b0; m_busy = 1'b1;
        #1 chk("mem_drop_wait", {24'd0, ctl}, 32'hF2);
        tick();
        f_ok = 1'b1;
        #1 chk("mem_drop_resp", {24'd0, ctl}, 32'hF3);
        tick();
        m_busy = 1'b0;
        #1 chk("mem_drop_run", {24'd0, ctl}, 32'h00);
        tick();
        chk("mem_drop_scnt", stall_cnt, 32'd7);
        chk("mem_drop_fcnt", flush_cnt, 32'd4);

        // reset asserted in DROP
        d_valid = 1'b1; d_is_jump = 1'b1; f_ok = 1'b0;
        #1 chk("jump3", {24'd0, ctl}, 32'h08);
        tick();
        idle();
        f_ok = 1'b0;
        #1 chk("drop_pre_rst", {24'd0, ctl}, 32'h88);
        chk("pre_rst_fcnt", flush_cnt, 32'd5);
        reset = 1'b1;
        #1 chk("rst_in_drop", {24'd0, ctl}, 32'h0E);
        tick();
        chk("rst_scnt", stall_cnt, 32'd0);
        chk("rst_fcnt", flush_cnt, 32'd0);
        reset = 1'b0;
        f_ok = 1'b1;
        #1 chk("post_rst_nodrop", {24'd0, ctl}, 32'h00);
        tick();
        chk("post_rst_fcnt", flush_cnt, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and redirect controller for the five-stage core. Watches decode source registers, in-flight destinations in E/M/W, the decode-stage branch/jump decision, and the instruction/data memory handshakes. From these it generates the per-stage stall and flush (bubble-insert) controls. It also owns a small FSM that discards the stale wrong-path fetch response after a redirect, and it keeps 32-bit stall and flush event counters for perf reporting.

## Interface
- W_BYPASS, 0, 1 means the register file writes through on the same cycle, so W-stage matches do not stall.
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- f_ok  in  1  fetch response valid this cycle
- d_valid  in  1  decode holds a real instruction (not a bubble)
- d_ra1, d_ra2  in  5  decode source register addresses
- d_use1, d_use2  in  1  instruction actually reads ra1 / ra2
- d_is_jump  in  1  taken branch or JAL resolved in decode
- e_valid, m_valid, w_valid  in  1  stage holds a real instruction
- e_dst, m_dst, w_dst  in  5  stage destination register
- e_wen, m_wen, w_wen  in  1  stage writes the register file
- m_busy  in  1  data-memory request outstanding, data not yet ok
- stall_f, stall_d, stall_e, stall_m  out  1  hold that pipeline register
- flush_d, flush_e, flush_w  out  1  load a bubble into that pipeline register
- drop_resp  out  1  discard the current fetch response
- stall_cnt  out  32  cycles with stall_d=1
- flush_cnt  out  32  redirects taken (jump flushes)

## Operation
- hit(x) = d_valid & use & x_valid & x_wen & (x_dst != 0) & (x_dst == ra). It is checked for E, M, and W, with W included only when W_BYPASS=0.
- raw = hit on either source. Decode has no forwarding path, so branch operands must be final in the register file.
- Priority is mem > raw > jump > fetch:
  - mem (m_busy=1): stall_f, stall_d, stall_e, stall_m all 1; flush_w=1; no other flush.
  - raw (m_busy=0): stall_f=1, stall_d=1, flush_e=1. A jump in decode is not taken while raw=1.
  - jump (m_busy=0, raw=0, d_is_jump=1): flush_d=1 (the wrong-path instruction behind it becomes a bubble). flush_cnt increments.
    - If f_ok=0 that cycle, the wrong-path request is still outstanding: the FSM goes RUN→DROP.
    - If f_ok=1, the wrong-path response is consumed by the flush and the FSM stays in RUN.
  - fetch (none of the above, f_ok=0): stall_f=1, flush_d=1.
- FSM states:
  - RUN: normal operation.
  - DROP: the next f_ok=1 response is stale. In that cycle drop_resp=1, flush_d=1, stall_f=0 (so the redirected PC issues), and the FSM returns to RUN. While f_ok=0, stay in DROP with stall_f=1 and flush_d=1.
  - DROP transitions are independent of m_busy. If mem and DROP coincide, mem stall outputs apply and drop_resp still follows f_ok.
- d_is_jump is ignored in DROP, because D holds a bubble there.
- stall_cnt increments on every cycle with stall_d=1 and saturates at 0xFFFF_FFFF. flush_cnt saturates the same way.
- All unused outputs are 0.

## Timing
- All stall/flush/drop outputs are combinational from the inputs and the FSM state, valid in the same cycle. No registered latency is added to the pipeline.
- The FSM state and both counters update on the rising clk edge.
- On reset: state=RUN, stall_cnt=0, flush_cnt=0. While reset=1, all stall outputs are 0, flush_d=flush_e=flush_w=1, and drop_resp=0.
- Reset asserted in DROP returns the FSM to RUN. The pending stale response is not dropped; fetch is reset alongside.
- raw and mem sustained over N cycles give N stall cycles with no counter double-count. A jump held by raw increments flush_cnt only once, on the cycle it is taken.
- A redirect followed by the stale response k cycles later produces drop_resp for exactly 1 cycle, at cycle k.

## Test plan
- Load-use: E has e_dst=5, e_wen=1; D reads ra1=5, d_use1=1 → stall_f=stall_d=flush_e=1. When E advances to M, the stall persists. When W_BYPASS=0, it clears only after W clears; stall_cnt=3.
- x0 and unused sources: e_dst=0 matching ra1=0, or d_use2=0 with ra2 matching → no stall, stall_cnt unchanged.
- Jump with response ready: d_is_jump=1, f_ok=1 → flush_d=1 for 1 cycle, state stays RUN, flush_cnt=1, drop_resp never asserted.
- Jump with fetch pending: d_is_jump=1, f_ok=0, then f_ok=1 three cycles later → DROP for 3 cycles; drop_resp=1 exactly at the f_ok cycle; the next cycle is RUN.
- Mem vs jump vs raw: m_busy=1 with raw and d_is_jump both set → only the mem stalls plus flush_w. When m_busy drops, raw stalls. When raw clears, the jump is taken; flush_cnt=1.
- Reset mid-DROP: assert reset in DROP → RUN, counters 0, flush_d=flush_e=flush_w=1 during reset; after reset, f_ok=1 gives drop_resp=0.
